// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Stages: unpack/exponent add/product, normalise, round-to-nearest-even and pack.
module fp_mult_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] a,
  input  logic [EXP_W+MANT_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] res,
  output logic                    ovf,
  output logic                    unf,
  output logic                    inv
);

  localparam int unsigned W  = EXP_W + MANT_W;
  localparam int unsigned FW = MANT_W - 1;
  localparam int unsigned PW = 2 * MANT_W;
  localparam logic [EXP_W-1:0]        EMAX_F = '1;
  localparam logic signed [EXP_W+1:0] EMAX_S = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] BIAS_S = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] ONE_S  = {{(EXP_W+1){1'b0}}, 1'b1};

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage 1: unpack and classify
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FW-1:0]     w_fa, w_fb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [PW-1:0]     w_ma, w_mb;
  logic signed [EXP_W+1:0] w_e1;

  assign {w_sa, w_ea, w_fa} = a;
  assign {w_sb, w_eb, w_fb} = b;
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EMAX_F) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EMAX_F) && (w_fb == '0);
  assign w_a_nan  = (w_ea == EMAX_F) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EMAX_F) && (w_fb != '0);
  assign w_ma     = {{MANT_W{1'b0}}, 1'b1, w_fa};
  assign w_mb     = {{MANT_W{1'b0}}, 1'b1, w_fb};
  assign w_e1     = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;

  logic                    r_v1, r_sign1, r_inv1, r_inf1, r_zero1;
  logic signed [EXP_W+1:0] r_e1;
  logic [PW-1:0]           r_p1;

  // Stage 2: normalise to a MANT_W mantissa plus guard and sticky
  logic [MANT_W-1:0]       w_mant2;
  logic                    w_g2, w_s2;
  logic signed [EXP_W+1:0] w_e2;

  always_comb begin
    w_mant2 = r_p1[PW-2:MANT_W-1];
    w_g2    = r_p1[MANT_W-2];
    w_s2    = |r_p1[MANT_W-3:0];
    w_e2    = r_e1;
    if (r_p1[PW-1]) begin
      w_mant2 = r_p1[PW-1:MANT_W];
      w_g2    = r_p1[MANT_W-1];
      w_s2    = |r_p1[MANT_W-2:0];
      w_e2    = r_e1 + ONE_S;
    end
  end

  logic                    r_v2, r_sign2, r_inv2, r_inf2, r_zero2, r_g2, r_s2;
  logic signed [EXP_W+1:0] r_e2;
  logic [MANT_W-1:0]       r_mant2;

  // Stage 3: round, then select result by exception priority
  logic                    w_rnd;
  logic [MANT_W:0]         w_sum;
  logic [MANT_W-1:0]       w_mant3;
  logic signed [EXP_W+1:0] w_e3;
  logic [W-1:0]            w_res3;
  logic                    w_ovf3, w_unf3, w_inv3;

  assign w_rnd = r_g2 && (r_s2 || r_mant2[0]);
  assign w_sum = {1'b0, r_mant2} + {{MANT_W{1'b0}}, w_rnd};

  always_comb begin
    w_mant3 = w_sum[MANT_W-1:0];
    w_e3    = r_e2;
    if (w_sum[MANT_W]) begin
      w_mant3 = {1'b1, {FW{1'b0}}};
      w_e3    = r_e2 + ONE_S;
    end
    w_ovf3 = 1'b0;
    w_unf3 = 1'b0;
    w_inv3 = 1'b0;
    w_res3 = {r_sign2, w_e3[EXP_W-1:0], w_mant3[FW-1:0]};
    if (r_inv2) begin
      w_res3 = {1'b0, EMAX_F, 1'b1, {(FW-1){1'b0}}};
      w_inv3 = 1'b1;
    end else if (r_inf2) begin
      w_res3 = {r_sign2, EMAX_F, {FW{1'b0}}};
    end else if (r_zero2) begin
      w_res3 = {r_sign2, {(W-1){1'b0}}};
    end else if (!w_e3[EXP_W+1] && (w_e3 >= EMAX_S)) begin
      w_res3 = {r_sign2, EMAX_F, {FW{1'b0}}};
      w_ovf3 = 1'b1;
    end else if (w_e3[EXP_W+1] || (w_e3 == '0)) begin
      w_res3 = {r_sign2, {(W-1){1'b0}}};
      w_unf3 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0; r_sign1 <= 1'b0; r_inv1 <= 1'b0; r_inf1 <= 1'b0; r_zero1 <= 1'b0;
      r_e1 <= '0;   r_p1 <= '0;
      r_v2 <= 1'b0; r_sign2 <= 1'b0; r_inv2 <= 1'b0; r_inf2 <= 1'b0; r_zero2 <= 1'b0;
      r_g2 <= 1'b0; r_s2 <= 1'b0;    r_e2 <= '0;     r_mant2 <= '0;
      out_valid <= 1'b0; res <= '0; ovf <= 1'b0; unf <= 1'b0; inv <= 1'b0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_sign1 <= w_sa ^ w_sb;
      r_inv1  <= w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
      r_inf1  <= w_a_inf || w_b_inf;
      r_zero1 <= w_a_zero || w_b_zero;
      r_e1    <= w_e1;
      r_p1    <= w_ma * w_mb;
      r_v2    <= r_v1;
      r_sign2 <= r_sign1;
      r_inv2  <= r_inv1;
      r_inf2  <= r_inf1;
      r_zero2 <= r_zero1;
      r_g2    <= w_g2;
      r_s2    <= w_s2;
      r_e2    <= w_e2;
      r_mant2 <= w_mant2;
      out_valid <= r_v2;
      res       <= w_res3;
      ovf       <= w_ovf3;
      unf       <= w_unf3;
      inv       <= w_inv3;
    end
  end

endmodule
